// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern blocks: active-area size,
// pattern indices, controller state encoding and the scroll wrap helper.
package vga_pkg;

   localparam logic [9:0] H_VALID = 10'd640;
   localparam logic [9:0] V_VALID = 10'd480;

   localparam logic [2:0] PAT_BARS  = 3'd0;
   localparam logic [2:0] PAT_CHECK = 3'd1;
   localparam logic [2:0] PAT_GRAD  = 3'd2;
   localparam logic [2:0] PAT_SOLID = 3'd3;

   typedef enum logic {
      AUTO = 1'b0,
      HOLD = 1'b1
   } pat_state_t;

   // 11-bit sum so a step near the line width cannot overflow before the wrap.
   function automatic logic [9:0] scroll_add(input logic [9:0] x,
                                             input logic [9:0] step,
                                             input logic [9:0] limit);
      logic [10:0] sum;
      sum = {1'b0, x} + {1'b0, step};
      return (sum >= {1'b0, limit}) ? 10'(sum - {1'b0, limit}) : sum[9:0];
   endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-end detector: combinational strobe on the last active pixel and a
// registered one-cycle frame_start pulse on the following cycle.
module vga_frame_tick
   import vga_pkg::*;
(
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   output logic       fe,
   output logic       frame_start
);

   assign fe = (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         frame_start <= 1'b0;
      else
         frame_start <= fe;
   end

endmodule

// File: rtl/vga_pat_ctrl.sv
// Test-pattern sequencer: auto-advances the pattern and scroll offset, and
// applies user next/hold requests, committing every change at frame end.
module vga_pat_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned N_PAT          = 4,
   parameter logic [7:0]  FRAMES_PER_PAT = 8'd60,
   parameter logic [9:0]  SCROLL_STEP    = 10'd2
)(
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       key_next,
   input  logic       key_hold,
   output logic [2:0] pat_sel,
   output logic [9:0] scroll_x,
   output logic       frame_start,
   output logic       hold_led
);

   localparam logic [2:0] PAT_LAST = 3'(N_PAT - 1);
   localparam logic [7:0] CNT_LAST = FRAMES_PER_PAT - 8'd1;

   logic       fe;
   pat_state_t state;
   pat_state_t state_nxt;
   logic [7:0] frame_cnt;
   logic       next_pend;
   logic       hold_pend;
   logic       do_next;
   logic       do_toggle;
   logic       advance;
   logic [2:0] pat_nxt;

   vga_frame_tick u_frame_tick (
      .vga_clk     (vga_clk),
      .sys_rst_n   (sys_rst_n),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .fe          (fe),
      .frame_start (frame_start)
   );

   // A key pulse landing on the fe cycle itself belongs to that frame end.
   always_comb begin
      do_next   = next_pend | key_next;
      do_toggle = hold_pend | key_hold;
      advance   = do_next || ((state == AUTO) && (frame_cnt == CNT_LAST));
      state_nxt = state;
      if (do_toggle)
         state_nxt = (state == AUTO) ? HOLD : AUTO;
      pat_nxt   = (pat_sel == PAT_LAST) ? PAT_BARS : pat_sel + 3'd1;
   end

   // The frame-end action uses the old state; a toggle takes effect afterwards.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= AUTO;
         pat_sel   <= PAT_BARS;
         scroll_x  <= 10'd0;
         frame_cnt <= 8'd0;
         next_pend <= 1'b0;
         hold_pend <= 1'b0;
         hold_led  <= 1'b0;
      end else if (fe) begin
         next_pend <= 1'b0;
         hold_pend <= 1'b0;
         state     <= state_nxt;
         hold_led  <= (state_nxt == HOLD);
         if (advance) begin
            pat_sel   <= pat_nxt;
            frame_cnt <= 8'd0;
            scroll_x  <= 10'd0;
         end else if (state == AUTO) begin
            frame_cnt <= frame_cnt + 8'd1;
            scroll_x  <= scroll_add(scroll_x, SCROLL_STEP, H_VALID);
         end
      end else begin
         if (key_next)
            next_pend <= 1'b1;
         if (key_hold)
            hold_pend <= 1'b1;
      end
   end

endmodule
